// File: rtl/cmp_sched_pkg.sv
// rtl/cmp_sched_pkg.sv - RISC-V opcode/func3 defines and requester IDs shared by the compare scheduler
package cmp_sched_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_BTYPE = 7'b1100011;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    localparam logic REQ_EXE = 1'b0;
    localparam logic REQ_BR  = 1'b1;

endpackage

// File: rtl/comparator_alu.sv
// rtl/comparator_alu.sv - combinational set-less-than unit for R/I-type SLT and SLTU
module comparator_alu
    import cmp_sched_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic is_cmp_opcode;

    always_comb begin
        is_cmp_opcode = (opcode == OPCODE_RTYPE) || (opcode == OPCODE_ITYPE);
        result        = ZERO;
        if (is_cmp_opcode) begin
            if (func3 == F3_SLT) begin
                result = {31'b0, ($signed(op1) < $signed(op2))};
            end else if (func3 == F3_SLTU) begin
                result = {31'b0, (op1 < op2)};
            end
        end
    end

endmodule

// File: rtl/cmp_sched.sv
// rtl/cmp_sched.sv - round-robin sharing of one comparator between SLT requests and branch resolution
module cmp_sched
    import cmp_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_op1,
    input  logic [31:0] r0_op2,
    input  logic [6:0]  r0_opcode,
    input  logic [2:0]  r0_func3,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_op1,
    input  logic [31:0] r1_op2,
    input  logic [2:0]  r1_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result
);

    logic        prio;
    logic        can_issue;
    logic        grant_r0;
    logic        grant_r1;
    logic        issue;

    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic [31:0] alu_result;

    logic [2:0]  br_func3;
    logic        br_eq;
    logic        br_taken;
    logic [31:0] issue_result;

    always_comb begin
        can_issue = !rsp_valid || rsp_ready;
        grant_r1  = r1_valid && (!r0_valid || prio);
        grant_r0  = r0_valid && !grant_r1;
        issue     = can_issue && (grant_r0 || grant_r1);
        r0_ready  = can_issue && grant_r0;
        r1_ready  = can_issue && grant_r1;
    end

    // Signed/unsigned branch conditions reuse SLT/SLTU; the equality pair never touches the ALU.
    always_comb begin
        case (r1_func3)
            F3_BLTU, F3_BGEU: br_func3 = F3_SLTU;
            default:          br_func3 = F3_SLT;
        endcase
    end

    always_comb begin
        if (grant_r1) begin
            alu_op1    = r1_op1;
            alu_op2    = r1_op2;
            alu_opcode = OPCODE_RTYPE;
            alu_func3  = br_func3;
        end else begin
            alu_op1    = r0_op1;
            alu_op2    = r0_op2;
            alu_opcode = r0_opcode;
            alu_func3  = r0_func3;
        end
    end

    comparator_alu u_alu (
        .op1    (alu_op1),
        .op2    (alu_op2),
        .opcode (alu_opcode),
        .func3  (alu_func3),
        .result (alu_result)
    );

    always_comb begin
        br_eq = (r1_op1 == r1_op2);
        case (r1_func3)
            F3_BLT, F3_BLTU: br_taken = alu_result[0];
            F3_BGE, F3_BGEU: br_taken = !alu_result[0];
            F3_BEQ:          br_taken = br_eq;
            F3_BNE:          br_taken = !br_eq;
            default:         br_taken = 1'b0;
        endcase
        issue_result = grant_r1 ? {31'b0, br_taken} : alu_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= REQ_EXE;
            rsp_result <= ZERO;
            prio       <= 1'b0;
        end else if (issue) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_r1 ? REQ_BR : REQ_EXE;
            rsp_result <= issue_result;
            prio       <= !grant_r1;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/cmp_sched.md
# cmp_sched

Round-robin scheduler that shares the single combinational compare unit (`comparator_alu`) between the execute-stage set-less-than path and the branch-resolution path. It accepts one compare request per cycle via valid/ready handshakes and translates branch conditions into compare operations. Results are returned through a single registered, back-pressurable response channel tagged with the requester ID.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `r0_valid` in 1: execute-stage request valid; SLT/SLTI/SLTU/SLTIU.
- `r0_ready` out 1: request 0 accepted this cycle when `r0_valid && r0_ready`.
- `r0_op1`, `r0_op2` in 32: rs1, and rs2 or immediate.
- `r0_opcode` in 7, `r0_func3` in 3: instruction fields.
- `r1_valid` in 1: branch-unit request valid.
- `r1_ready` out 1: request 1 accepted when `r1_valid && r1_ready`.
- `r1_op1`, `r1_op2` in 32: rs1, rs2.
- `r1_func3` in 3: branch func3; opcode is implicitly BTYPE.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: 0 = requester 0, 1 = requester 1.
- `rsp_result` out 32: compare result or branch-taken flag in bit 0.

## Operation
- State: response register `{rsp_valid, rsp_id, rsp_result}` and round-robin pointer `prio`. `prio` = 0 means requester 0 wins ties.
- `can_issue = !rsp_valid || rsp_ready`.
- Grant is computed combinationally:
  - Only r0 valid: grant r0.
  - Only r1 valid: grant r1.
  - Both valid: grant to `prio`.
- `rX_ready = can_issue && granted(X)`. The non-granted requester sees ready = 0 and must hold its request stable.
- On an accepted grant, `prio` ← complement of the granted ID. With no grant, `prio` is unchanged.
- Requester 0 path: its operands, opcode and func3 drive `comparator_alu` unchanged. `rsp_result` = comparator output. Unsupported func3/opcode combinations yield 0.
- Requester 1 translation (opcode forced to RTYPE):
  - BLT/BGE (100/101): func3 = 010, signed compare.
  - BLTU/BGEU (110/111): func3 = 011, unsigned compare.
  - BEQ/BNE (000/001): use the local 32-bit equality `op1 == op2`; the comparator output is ignored.
  - taken = lt for BLT/BLTU; !lt for BGE/BGEU; eq for BEQ; !eq for BNE.
  - Reserved func3 (010/011) gives taken = 0.
  - `rsp_result = {31'b0, taken}`.
- Response register behaviour:
  - Accepted issue: loads `rsp_valid` = 1, `rsp_id`, `rsp_result`.
  - `rsp_valid && rsp_ready` with no issue: clears `rsp_valid` to 0.
  - `rsp_valid && !rsp_ready`: holds all response fields; both `rX_ready` = 0 (stall).

## Timing
- Reset (async assert, sync deassert handled upstream): `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `prio` = 0. `r0_ready`/`r1_ready` follow the combinational rule, so a request can be accepted in the first cycle after reset.
- Latency: request accepted at edge N gives the response visible after edge N, i.e. `rsp_valid` high in cycle N+1.
- Throughput: one request per cycle while `rsp_ready` = 1. Simultaneous response drain and new issue in the same cycle is legal and keeps `rsp_valid` = 1.
- Both requesters held valid with `rsp_ready` = 1 gives strictly alternating grants. Maximum wait for any requester is 1 grant.
- Reset mid-operation discards any pending response; in-flight requests must be re-presented.
- No combinational path from `rsp_ready` to `rsp_result`. The only combinational paths are `rsp_ready` → `rX_ready` and `rX_valid` → `rY_ready`.

## Structure
- Opcode, func3 (including BTYPE codes) and ZERO constants live in the shared RISC-V defines package.
- Local requester-ID constants `REQ_EXE` = 0 and `REQ_BR` = 1 go in the same package.
- Single sub-module: one `comparator_alu` instance fed by the grant mux. The branch translation, equality compare, arbiter and response register are inline.

## Test plan
- Reset mid-stream: assert `rst_n` = 0 while `rsp_valid` = 1 → all outputs 0 immediately (asynchronous); first post-reset request accepted.
- SLT: r0 SLT with op1 = 0xFFFFFFFF, op2 = 1 → next cycle `rsp_valid` = 1, `rsp_id` = 0, `rsp_result` = 1. Same operands with SLTU → result 0.
- Branches:
  - r1 BGEU, op1 = 0x80000000, op2 = 1 → `rsp_id` = 1, result = 1.
  - r1 BGE, same operands → 0.
  - BNE, op1 = op2 = 0x1234 → 0.
  - Reserved func3 010 → 0.
- Contention: both valid for 4 cycles with `rsp_ready` = 1 → grants r0, r1, r0, r1 and `rsp_id` sequence 0, 1, 0, 1.
- Back-pressure: response pending with `rsp_ready` = 0 for 3 cycles → both readies 0; `rsp_result`/`rsp_id` stable. Release → drain and new issue in the same cycle; `rsp_valid` stays 1.
- Idle: no valids and `rsp_ready` = 1 → `rsp_valid` falls to 0 one cycle after drain; `prio` unchanged.
